// File: rtl/rv_fetch_stage_pkg.sv
// Shared types for the RISC-V instruction fetch stage.
// Holds the fetch FSM state encoding and the buffered entry layout.
package rv_fetch_stage_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           inst;
    } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_stage_fifo.sv
// Small synchronous FIFO with single-edge flush.
// Used both as the instruction buffer and as the request PC tag queue.
module rv_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;
    assign rdata   = mem[rptr];

    // Storage array, written only on an accepted push.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers and occupancy; flush empties the queue in one edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv_fetch_stage.sv
// Instruction fetch stage: credit-limited requests, PC tagging,
// in-order buffering and redirect flush of in-flight responses.
module rv_fetch_stage
    import rv_fetch_stage_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [CW-1:0]   out_q;
    logic [CW-1:0]   out_d;
    logic [CW-1:0]   kill_q;
    logic [CW-1:0]   kill_d;
    logic [CW-1:0]   inst_cnt;
    logic [CW-1:0]   tag_cnt;
    logic [CW:0]     used;
    logic            inst_full;
    logic            inst_empty;
    logic            tag_full;
    logic            tag_empty;
    logic [XLEN-1:0] tag_pc;
    fetch_entry_t    push_e;
    fetch_entry_t    head_e;
    logic            acc;
    logic            redir;
    logic            run_rsp;
    logic            unused_ok;

    assign used = {1'b0, out_q} + {1'b0, inst_cnt};
    assign imem_req_valid = (state_q == RUN) &&
                            (used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign acc     = imem_req_valid && imem_req_ready;
    assign redir   = redirect_valid && (state_q != BOOT);
    assign run_rsp = imem_rsp_valid && (state_q == RUN);
    assign out_d   = out_q + CW'(acc) - CW'(imem_rsp_valid);

    // Buffer entry: response data tagged with its request address.
    always_comb begin
        push_e      = '0;
        push_e.pc   = FETCH_XLEN'(tag_pc);
        push_e.inst = imem_rsp_data;
    end

    // Next state, kill count and fetch PC; redirect wins over all.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redir && out_d != '0) state_d = FLUSH;
            end
            FLUSH: begin
                if (redir)
                    state_d = (out_d != '0) ? FLUSH : RUN;
                else if (imem_rsp_valid && kill_q == CW'(1))
                    state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
        if (redir) begin
            kill_d     = out_d;
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (state_q == FLUSH && imem_rsp_valid)
                kill_d = kill_q - CW'(1);
            if (acc)
                fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            kill_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            kill_q     <= kill_d;
        end
    end

    rv_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (run_rsp),
        .wdata (push_e),
        .pop   (inst_ready),
        .flush (redir),
        .rdata (head_e),
        .full  (inst_full),
        .empty (inst_empty),
        .count (inst_cnt)
    );

    rv_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (acc),
        .wdata (fetch_pc_q),
        .pop   (run_rsp),
        .flush (redir),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_cnt)
    );

    assign inst_valid = !inst_empty;
    assign inst_data  = inst_valid ? head_e.inst : '0;
    assign inst_pc    = inst_valid ? XLEN'(head_e.pc) : '0;

    assign unused_ok = ^{inst_full, tag_full, tag_empty,
                         tag_cnt, redirect_pc[1:0]};

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Bench for rv_fetch_stage: transaction-level model with
// generation-tagged requests, directed scenarios and random traffic.
module tb_rv_fetch_stage;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RST;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        RST_b;
    logic        req_valid_b;
    logic        req_ready_b;
    logic [31:0] req_addr_b;
    logic        rsp_valid_b;
    logic [31:0] rsp_data_b;
    logic        redir_valid_b;
    logic [31:0] redir_pc_b;
    logic        inst_valid_b;
    logic        inst_ready_b;
    logic [31:0] inst_data_b;
    logic [31:0] inst_pc_b;

    rv_fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    rv_fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (DEPTH)
    ) dut_wrap (
        .CLK            (CLK),
        .RST            (RST_b),
        .imem_req_valid (req_valid_b),
        .imem_req_ready (req_ready_b),
        .imem_req_addr  (req_addr_b),
        .imem_rsp_valid (rsp_valid_b),
        .imem_rsp_data  (rsp_data_b),
        .redirect_valid (redir_valid_b),
        .redirect_pc    (redir_pc_b),
        .inst_valid     (inst_valid_b),
        .inst_ready     (inst_ready_b),
        .inst_data      (inst_data_b),
        .inst_pc        (inst_pc_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    pend_t       pend[$];
    ent_t        expq[$];
    logic [31:0] m_pc;
    int          gen;
    bit          boot;
    int          cyc;
    int          rsp_pct;
    int          n_chk;
    int          n_fail;
    logic [31:0] acc_log[$];
    logic [31:0] inst_log[$];
    logic [31:0] acc_b[$];

    always @(posedge CLK) begin
        if (req_valid_b && req_ready_b) acc_b.push_back(req_addr_b);
    end

    function automatic logic [31:0] memf(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] qat(logic [31:0] q[$], int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(string name, logic [63:0] act,
                       logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_flushing();
        foreach (pend[i]) if (pend[i].gen != gen) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_req_valid();
        return !boot && !m_flushing() &&
               (pend.size() + expq.size() < DEPTH);
    endfunction

    task automatic check();
        bit v;
        v = m_req_valid();
        chk("req_valid", imem_req_valid, v);
        if (v) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", inst_valid, expq.size() != 0);
        if (expq.size() != 0) begin
            chk("inst_pc", inst_pc, expq[0].pc);
            chk("inst_data", inst_data, expq[0].data);
        end
    endtask

    task automatic model_update();
        bit          a;
        bit          rd;
        int          g0;
        logic [31:0] pc0;
        pend_t       p;
        a   = m_req_valid() && imem_req_ready;
        rd  = redirect_valid && !boot;
        g0  = gen;
        pc0 = m_pc;
        if (expq.size() > 0 && inst_ready && !rd)
            void'(expq.pop_front());
        if (imem_rsp_valid && pend.size() > 0) begin
            p = pend.pop_front();
            if (!rd && p.gen == gen)
                expq.push_back('{p.addr, memf(p.addr)});
        end
        if (rd) begin
            expq.delete();
            gen++;
            m_pc = {redirect_pc[31:2], 2'b00};
        end else if (a) begin
            m_pc = m_pc + 32'd4;
        end
        if (a) pend.push_back('{pc0, g0, cyc + 1});
        boot = 1'b0;
    endtask

    task automatic drive_rsp();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc &&
            $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend[0].addr);
        end
    endtask

    task automatic step();
        if (imem_req_valid && imem_req_ready)
            acc_log.push_back(imem_req_addr);
        if (inst_valid && inst_ready && !redirect_valid)
            inst_log.push_back(inst_pc);
        model_update();
        @(posedge CLK);
        #1;
        cyc++;
        check();
        drive_rsp();
    endtask

    task automatic do_reset();
        RST            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        pend.delete();
        expq.delete();
        gen  = 0;
        m_pc = 32'h0;
        boot = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        RST = 1'b1;
        acc_log.delete();
        inst_log.delete();
        chk("boot_req_valid", imem_req_valid, 0);
    endtask

    initial begin
        int k;
        int n0;
        int disc;
        bit stale;
        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        rsp_pct = 100;
        RST     = 1'b0;
        RST_b   = 1'b0;
        req_ready_b   = 1'b1;
        rsp_valid_b   = 1'b0;
        rsp_data_b    = '0;
        redir_valid_b = 1'b0;
        redir_pc_b    = '0;
        inst_ready_b  = 1'b0;

        // Streaming from reset with a 1-cycle memory.
        do_reset();
        chk("wrap_rst_addr", req_addr_b, 32'hFFFF_FFF8);
        RST_b = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        rsp_pct        = 100;
        repeat (12) step();
        chk("stream_acc0", qat(acc_log, 0), 32'h0);
        chk("stream_acc1", qat(acc_log, 1), 32'h4);
        chk("stream_acc2", qat(acc_log, 2), 32'h8);
        chk("stream_inst0", qat(inst_log, 0), 32'h0);
        chk("stream_inst1", qat(inst_log, 1), 32'h4);
        chk("stream_inst2", qat(inst_log, 2), 32'h8);

        // Decode stall: credits stop requests at FIFO_DEPTH.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (12) step();
        chk("stall_acc_cnt", acc_log.size(), 4);
        chk("stall_req_off", imem_req_valid, 0);
        chk("stall_inst_on", inst_valid, 1);
        inst_ready = 1'b1;
        repeat (12) step();
        chk("drain_inst0", qat(inst_log, 0), 32'h0);
        chk("drain_inst1", qat(inst_log, 1), 32'h4);
        chk("drain_inst2", qat(inst_log, 2), 32'h8);
        chk("drain_inst3", qat(inst_log, 3), 32'hC);
        chk("resume_acc", qat(acc_log, 4), 32'h10);

        // Redirect with three requests in flight.
        do_reset();
        inst_ready     = 1'b1;
        rsp_pct        = 0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && acc_log.size() < 3; i++) step();
        imem_req_ready = 1'b0;
        chk("flush_out3", acc_log.size(), 3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("flush_no_req", imem_req_valid, 0);
        rsp_pct        = 100;
        imem_req_ready = 1'b1;
        stale = 1'b0;
        k = 0;
        while (!imem_req_valid && k < 20) begin
            if (inst_valid) stale = 1'b1;
            step();
            k++;
        end
        chk("flush_inst_quiet", stale, 0);
        chk("flush_req_back", imem_req_valid, 1);
        chk("flush_first_req", imem_req_addr, 32'h100);
        n0 = inst_log.size();
        repeat (6) step();
        chk("flush_first_inst", qat(inst_log, n0), 32'h100);

        // Redirect with nothing outstanding, unaligned target.
        imem_req_ready = 1'b0;
        repeat (8) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        chk("idle_redir_valid", imem_req_valid, 1);
        chk("idle_redir_addr", imem_req_addr, 32'h200);

        // Redirect together with an inst handshake and a response.
        do_reset();
        rsp_pct        = 0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (8) step();
        imem_req_ready = 1'b0;
        rsp_pct        = 100;
        step();
        step();
        chk("combo_pre_inst", inst_valid, 1);
        chk("combo_pre_rsp", imem_rsp_valid, 1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        chk("combo_fifo_empty", inst_valid, 0);
        imem_req_ready = 1'b1;
        disc  = 0;
        stale = 1'b0;
        k = 0;
        while (!imem_req_valid && k < 20) begin
            if (imem_rsp_valid) disc++;
            if (inst_valid) stale = 1'b1;
            step();
            k++;
        end
        chk("combo_discarded", disc, 2);
        chk("combo_no_stale", stale, 0);
        chk("combo_first_req", imem_req_addr, 32'h300);
        n0 = inst_log.size();
        repeat (6) step();
        chk("combo_first_inst", qat(inst_log, n0), 32'h300);

        // PC wrap on the second instance.
        chk("wrap_acc0", qat(acc_b, 0), 32'hFFFF_FFF8);
        chk("wrap_acc1", qat(acc_b, 1), 32'hFFFF_FFFC);
        chk("wrap_acc2", qat(acc_b, 2), 32'h0);

        // Random traffic against the model.
        do_reset();
        rsp_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            int ip;
            ip = ((i / 100) % 2 == 1) ? 20 : 85;
            imem_req_ready = ($urandom_range(99) < 70);
            inst_ready     = ($urandom_range(99) < ip);
            redirect_valid = ($urandom_range(99) < 3);
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
